stopwatch_ctrl: RTL

- Sequencing controller for the 1 Hz enable generator: consumes its one-cycle `tick` and runs an mm:ss BCD stopwatch.
- Start/stop/lap/clear FSM driven by pre-debounced single-cycle button pulses.
- Issues `div_clear` to re-phase the divider on every (re)start.
- Sits between the OneHertz tick source and the 7-segment display mux in the top level.

---
 rtl/stopwatch_ctrl_pkg.sv | 45 ++++
 rtl/stopwatch_ctrl_digit.sv | 42 ++++
 rtl/stopwatch_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the mm:ss stopwatch controller: FSM state
// encoding, BCD digit width and the digit-position layout of the chain.
package stopwatch_ctrl_pkg;

  // Width of one BCD digit.
  localparam int DIGIT_W = 4;

  // Number of digits in the mm:ss chain.
  localparam int NUM_DIGITS = 4;

  // Digit positions inside the chain, least significant first.
  localparam int POS_SO = 0;
  localparam int POS_ST = 1;
  localparam int POS_MO = 2;
  localparam int POS_MT = 3;

  // Controller states; the encoding is fixed so the top level and any
  // debug tap see the same values.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  // Highest legal value of the digit at position pos.  The ones digits
  // always run 0..9; the tens digits take their limit from the caller.
  function automatic int digit_max(input int pos, input int sec_tens_max,
                                   input int min_tens_max);
    int result;
    result = 9;
    if (pos == POS_ST) begin
      result = sec_tens_max;
    end else if (pos == POS_MT) begin
      result = min_tens_max;
    end
    return result;
  endfunction

  // True in the states where the live count is allowed to advance.
  function automatic logic is_counting(input state_t st);
    return (st == RUN) || (st == LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_digit.sv
// One BCD digit of the stopwatch carry chain.  Counts 0..MAX_VAL on inc,
// wrapping to 0 and raising carry in the same cycle it wraps.  Any value
// above MAX_VAL (or above 9) is treated as "at the top", so a corrupted
// digit is forced back to 0 with a carry on the next increment.
module bcd_digit
  import stopwatch_ctrl_pkg::*;
#(
  parameter int MAX_VAL = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               inc,
  output logic [DIGIT_W-1:0] value,
  output logic               carry
);

  localparam logic [DIGIT_W-1:0] TOP = DIGIT_W'(MAX_VAL);
  localparam logic [DIGIT_W-1:0] BCD_MAX = DIGIT_W'(9);

  logic at_top;

  // Wrap condition: at the programmed limit or holding a non-BCD value.
  always_comb begin
    at_top = (value >= TOP) || (value > BCD_MAX);
    carry  = inc && at_top;
  end

  // Digit register: reset/clear to 0, otherwise step on inc.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      value <= '0;
    end else if (inc) begin
      if (at_top) begin
        value <= '0;
      end else begin
        value <= value + DIGIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// mm:ss BCD stopwatch controller.  A start/stop/lap/clear FSM gates the
// 1 Hz tick into a four-digit BCD carry chain, keeps a lap snapshot, and
// presents either the live count or the snapshot on registered outputs.
// div_clear re-phases the external 1 Hz divider on every (re)start.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int MIN_TENS_MAX = 5,
  parameter int SEC_TENS_MAX = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         btn_ss,
  input  logic         btn_lc,
  output logic [3:0]   disp_mt,
  output logic [3:0]   disp_mo,
  output logic [3:0]   disp_st,
  output logic [3:0]   disp_so,
  output logic         running,
  output logic         lap_active,
  output logic         div_clear,
  output logic         wrap
);

  // ---------------------------------------------------------------------
  // FSM state and decoded actions
  // ---------------------------------------------------------------------
  state_t state_reg;
  state_t state_next;

  logic start_pulse;   // entering RUN from IDLE or PAUSE
  logic lap_capture;   // RUN -> LAP, snapshot the live count
  logic clear_all;     // PAUSE -> IDLE, zero live count and lap register
  logic count_en;      // live count advances this edge

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode.  btn_ss has priority: when both buttons arrive in
  // the same cycle only the start/stop action is taken.
  always_comb begin
    state_next  = state_reg;
    start_pulse = 1'b0;
    lap_capture = 1'b0;
    clear_all   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (btn_ss) begin
          state_next  = RUN;
          start_pulse = 1'b1;
        end
      end
      RUN: begin
        if (btn_ss) begin
          state_next = PAUSE;
        end else if (btn_lc) begin
          state_next  = LAP;
          lap_capture = 1'b1;
        end
      end
      LAP: begin
        if (btn_ss) begin
          state_next = PAUSE;
        end else if (btn_lc) begin
          state_next = RUN;
        end
      end
      PAUSE: begin
        if (btn_ss) begin
          state_next  = RUN;
          start_pulse = 1'b1;
        end else if (btn_lc) begin
          state_next = IDLE;
          clear_all  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Counting is qualified by the state before the edge, so a tick that
  // coincides with a stop press still counts and one that coincides with
  // a start press does not.
  always_comb begin
    count_en = tick && is_counting(state_reg);
  end

  // ---------------------------------------------------------------------
  // BCD carry chain: position 0 = second ones ... position 3 = minute tens
  // ---------------------------------------------------------------------
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] live_digits;
  logic [NUM_DIGITS:0]                carry_chain;

  assign carry_chain[0] = count_en;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      bcd_digit #(
        .MAX_VAL(digit_max(gi, SEC_TENS_MAX, MIN_TENS_MAX))
      ) u_digit (
        .clk   (clk),
        .reset (reset),
        .clear (clear_all),
        .inc   (carry_chain[gi]),
        .value (live_digits[gi]),
        .carry (carry_chain[gi+1])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Lap register and rollover flag
  // ---------------------------------------------------------------------
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] lap_reg;
  logic                               wrap_pend_reg;

  // Lap snapshot takes the pre-increment live value on capture.
  always_ff @(posedge clk) begin
    if (reset || clear_all) begin
      lap_reg <= '0;
    end else if (lap_capture) begin
      lap_reg <= live_digits;
    end
  end

  // Remember a full rollover so the wrap output lines up with the
  // display first showing 00:00.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_pend_reg <= 1'b0;
    end else begin
      wrap_pend_reg <= carry_chain[NUM_DIGITS];
    end
  end

  // ---------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] shown_digits;

  // Display source: frozen lap snapshot while in LAP, else live count.
  always_comb begin
    shown_digits = live_digits;
    if (state_reg == LAP) begin
      shown_digits = lap_reg;
    end
  end

  // Output register stage; everything visible to the top level is a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_mt    <= '0;
      disp_mo    <= '0;
      disp_st    <= '0;
      disp_so    <= '0;
      running    <= 1'b0;
      lap_active <= 1'b0;
      div_clear  <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      disp_mt    <= shown_digits[POS_MT];
      disp_mo    <= shown_digits[POS_MO];
      disp_st    <= shown_digits[POS_ST];
      disp_so    <= shown_digits[POS_SO];
      running    <= is_counting(state_reg);
      lap_active <= (state_reg == LAP);
      div_clear  <= start_pulse;
      wrap       <= wrap_pend_reg;
    end
  end

endmodule
